// File: rtl/imem_uart_loader.sv
// UART byte stream to instruction memory loader: frames of SYNC, LEN (16b), LEN words LSB-first.
// Define IMEM_LOADER_CSUM_EN to require a trailing mod-256 checksum byte after the data.
module imem_uart_loader #(
  parameter int unsigned IMEM_WORDS  = 1024,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        prog_ena,
  output logic [3:0]  imem_wea,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    FINISH
  } state_t;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = FINISH;
`endif

  state_t state_reg, state_next;
  logic [15:0] len_reg, len_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [23:0] word_buf_reg, word_buf_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic        prog_ena_next, load_done_next, load_err_next;
  logic [3:0]  imem_wea_next;
  logic [31:0] imem_addr_next, imem_din_next;
  logic [15:0] words_loaded_next;
  logic [15:0] len_full;
  logic        counting, abort, go_idle;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_reg, csum_next;
`endif

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      word_buf_reg <= '0;
      to_cnt_reg   <= '0;
      prog_ena     <= 1'b0;
      imem_wea     <= 4'h0;
      imem_addr    <= '0;
      imem_din     <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      word_buf_reg <= word_buf_next;
      to_cnt_reg   <= to_cnt_next;
      prog_ena     <= prog_ena_next;
      imem_wea     <= imem_wea_next;
      imem_addr    <= imem_addr_next;
      imem_din     <= imem_din_next;
      load_done    <= load_done_next;
      load_err     <= load_err_next;
      words_loaded <= words_loaded_next;
`ifdef IMEM_LOADER_CSUM_EN
      csum_reg     <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    byte_cnt_next     = byte_cnt_reg;
    word_buf_next     = word_buf_reg;
    prog_ena_next     = prog_ena;
    imem_wea_next     = 4'h0;
    imem_addr_next    = imem_addr;
    imem_din_next     = imem_din;
    load_done_next    = 1'b0;
    load_err_next     = 1'b0;
    words_loaded_next = words_loaded;
`ifdef IMEM_LOADER_CSUM_EN
    csum_next         = csum_reg;
`endif
    len_full = {rx_data, len_reg[7:0]};
    abort    = 1'b0;
    go_idle  = 1'b0;
    counting = (state_reg != IDLE) && (state_reg != FINISH);

    if (rx_valid)      to_cnt_next = '0;
    else if (counting) to_cnt_next = to_cnt_reg + TW'(1);
    else               to_cnt_next = to_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_next    = LEN0;
          prog_ena_next = 1'b1;
        end
      end
      LEN0: begin
        if (rx_valid) begin
          len_next   = {8'h00, rx_data};
          state_next = LEN1;
        end
      end
      LEN1: begin
        if (rx_valid) begin
          len_next = len_full;
          if (32'(len_full) > IMEM_WORDS) begin
            abort = 1'b1;
          end else begin
            words_loaded_next = '0;
            state_next        = (len_full == 16'd0) ? TAIL : DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
`ifdef IMEM_LOADER_CSUM_EN
          csum_next = csum_reg + rx_data;
`endif
          byte_cnt_next = byte_cnt_reg + 2'd1;
          case (byte_cnt_reg)
            2'd0: word_buf_next[7:0]   = rx_data;
            2'd1: word_buf_next[15:8]  = rx_data;
            2'd2: word_buf_next[23:16] = rx_data;
            default: begin
              // Fourth byte completes the word; it is written straight from rx_data.
              imem_wea_next     = 4'hF;
              imem_din_next     = {rx_data, word_buf_reg};
              imem_addr_next    = {14'b0, words_loaded, 2'b00};
              words_loaded_next = words_loaded + 16'd1;
              if (words_loaded + 16'd1 == len_reg) state_next = TAIL;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_reg) state_next = FINISH;
          else                     abort = 1'b1;
        end
      end
`endif
      FINISH: begin
        load_done_next = 1'b1;
        go_idle        = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (!rx_valid && counting && to_cnt_reg == TW'(TIMEOUT_CYC - 1)) abort = 1'b1;

    if (abort) begin
      load_err_next = 1'b1;
      go_idle       = 1'b1;
    end
    if (go_idle) begin
      state_next    = IDLE;
      prog_ena_next = 1'b0;
      byte_cnt_next = '0;
      to_cnt_next   = '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_next     = '0;
`endif
    end
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Upstream feeder of the reprogrammable fetch stage.
- Consumes bytes from the UART receiver and packs them into 32-bit little-endian instruction words.
- Writes the words sequentially into instruction memory starting at address 0.
- Drives prog_ena, which holds the fetch PC at 0 and gives the loader ownership of the imem write port for the whole load.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in words; word counts above this are rejected.
- TIMEOUT_CYC, 1000000, maximum idle clk cycles between bytes once a load has started.
- SYNC_BYTE, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock
- Rst_n  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a new UART byte
- rx_data  input  8  received byte
- prog_ena  output  1  load in progress; fetch holds its PC at 0 and imem is owned by the loader
- imem_wea  output  4  byte write enables; 4'hF for one cycle per completed word, else 4'h0
- imem_addr  output  32  byte address of the word being written (word_idx*4)
- imem_din  output  32  assembled instruction word
- load_done  output  1  one-cycle pulse: load completed successfully
- load_err  output  1  one-cycle pulse: load aborted
- words_loaded  output  16  number of words written in the current or last load

Behaviour:
- Reset (async, Rst_n=0): state IDLE, prog_ena=0, imem_wea=0, imem_addr=0, imem_din=0, load_done=0, load_err=0, words_loaded=0, byte and timeout counters 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN*4 data bytes (LSB first per word), then CSUM byte (only with the optional feature).
- States: IDLE, LEN0, LEN1, DATA, CSUM, FINISH.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> LEN0 and prog_ena=1 from the next cycle.
  - Any other byte is ignored.
- LEN0: latch LEN[7:0] -> LEN1.
- LEN1: latch LEN[15:8].
  - LEN > IMEM_WORDS -> load_err pulse, back to IDLE.
  - LEN == 0 -> CSUM if enabled, else FINISH.
  - Otherwise -> DATA, words_loaded=0.
- DATA:
  - Each byte shifts into byte lane byte_cnt (0..3).
  - On the 4th byte: next cycle imem_wea=4'hF, imem_din=assembled word, imem_addr=words_loaded*4, words_loaded++.
  - When words_loaded reaches LEN -> CSUM or FINISH.
  - Write latency: exactly 1 cycle after the 4th rx_valid.
- CSUM: compare the received byte against the mod-256 sum of all data bytes.
  - Match -> FINISH.
  - Mismatch -> load_err, IDLE.
- FINISH: load_done pulses for one cycle, prog_ena drops the same cycle, then IDLE.
- Timeout:
  - Counter is cleared on every rx_valid and counts only in LEN0, LEN1, DATA and CSUM.
  - Reaching TIMEOUT_CYC -> load_err, IDLE, prog_ena=0, partial byte discarded.
  - Words already written stay in imem; words_loaded keeps the partial count.
- Any error or return to IDLE clears byte_cnt, the checksum accumulator and prog_ena.
- SYNC_BYTE received mid-frame is treated as data, never as a restart.
- rx_valid during the imem write cycle is accepted normally; a byte is never dropped.
- Reset mid-load: all outputs go to reset values immediately, prog_ena deasserts asynchronously, and no write is issued.
- load_done and load_err are mutually exclusive and never asserted together with imem_wea.

Optional Feature:
- Macro IMEM_LOADER_CSUM_EN.
- Defined: the CSUM state exists and a trailing checksum byte is required; mismatch -> load_err.
- Undefined: no CSUM state and no accumulator logic; after the last word (or LEN==0) go directly to FINISH.

Test Plan:
- Basic load: A5,02,00,13,00,00,00,93,00,10,00,(CSUM B6) -> writes 32'h00000013 @0 and 32'h00100093 @4, each one cycle after its 4th byte; load_done=1 once; words_loaded=2; prog_ena high from after A5 until the done cycle.
- Oversize: A5,01,04 with IMEM_WORDS=1024 (LEN=1025) -> load_err pulse, no imem_wea, prog_ena=0.
- Timeout: A5,01,00,AA,BB then silence for TIMEOUT_CYC cycles -> load_err, no write, state IDLE; next frame loads correctly.
- Checksum error (macro on): one-word frame 11,22,33,44 with CSUM 00 -> word 32'h44332211 written @0, then load_err, no load_done.
- Async reset: deassert Rst_n while the 3rd data byte arrives -> prog_ena=0 and imem_wea=0 the same cycle; a following frame A5,00,00,(00) -> load_done with words_loaded=0.
- Noise in IDLE: bytes 00,FF,5A before A5 -> ignored; prog_ena stays 0 until A5 arrives.
